// File: rtl/imem_fetch.sv
`default_nettype none
// ============================================================================
// imem_fetch : registered instruction memory for the IF stage, with stall/flush,
//              fault detection, program-load port and optional post-reset clear.
// Revision   : 1.0
// ============================================================================
module imem_fetch #(
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DEPTH          = 64,
  parameter logic [DATA_W-1:0] NOP            = '0,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_en,
  input  logic              stall,
  input  logic              flush,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] instruction,
  output logic              inst_valid,
  output logic              fault,
  output logic              prog_err,
  output logic              ready
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef logic [ADDR_W-3:0] widx_t;
  typedef logic [IDX_W-1:0]  idx_t;

  localparam widx_t c_depth_w  = widx_t'(DEPTH);
  localparam idx_t  c_last_idx = idx_t'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t            r_state;
  idx_t              r_clear_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_instr;
  logic              r_valid;
  logic              r_fault;
  logic              r_prog_err;

  // Range checks use the full word index so high address bits never alias.
  widx_t w_pc_widx;
  widx_t w_prog_widx;
  idx_t  w_pc_idx;
  idx_t  w_prog_idx;
  logic  w_pc_ok;
  logic  w_prog_ok;

  assign w_pc_widx   = pc[ADDR_W-1:2];
  assign w_prog_widx = prog_addr[ADDR_W-1:2];
  assign w_pc_idx    = w_pc_widx[IDX_W-1:0];
  assign w_prog_idx  = w_prog_widx[IDX_W-1:0];
  assign w_pc_ok     = (pc[1:0] == 2'b00) && (w_pc_widx < c_depth_w);
  assign w_prog_ok   = (prog_addr[1:0] == 2'b00) && (w_prog_widx < c_depth_w);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      r_clear_ptr <= '0;
      r_instr     <= NOP;
      r_valid     <= 1'b0;
      r_fault     <= 1'b0;
      r_prog_err  <= 1'b0;
    end else begin
      r_prog_err <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          r_clear_ptr <= r_clear_ptr + idx_t'(1);
          if (r_clear_ptr == c_last_idx) begin
            r_clear_ptr <= '0;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          r_prog_err <= prog_we && !w_prog_ok;
          if (flush) begin
            r_instr <= NOP;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
          end else if (stall) begin
            r_instr <= r_instr;
          end else if (fetch_en && w_pc_ok) begin
            r_instr <= r_mem[w_pc_idx];
            r_valid <= 1'b1;
            r_fault <= 1'b0;
          end else if (fetch_en) begin
            r_instr <= NOP;
            r_valid <= 1'b0;
            r_fault <= 1'b1;
          end else begin
            r_valid <= 1'b0;
            r_fault <= 1'b0;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  // Same-edge write and fetch of one word: the fetch register takes the old data.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_clear_ptr] <= NOP;
    end else if (prog_we && w_prog_ok) begin
      r_mem[w_prog_idx] <= prog_data;
    end
  end

  assign instruction = r_instr;
  assign inst_valid  = r_valid;
  assign fault       = r_fault;
  assign prog_err    = r_prog_err;
  assign ready       = (r_state == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch.sv
`default_nettype none
// ============================================================================
// tb_imem_fetch : scoreboard bench driving two imem_fetch instances (swept and
//                 unswept) from shared stimulus against a behavioural model.
// Revision      : 1.0
// ============================================================================
module tb_imem_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = '0;
  logic        fetch_en = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        prog_we = 1'b0;
  logic [31:0] prog_addr = '0;
  logic [31:0] prog_data = '0;

  logic [31:0] ins0, ins1;
  logic        v0, v1, f0, f1, pe0, pe1, rd0, rd1;

  imem_fetch #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .NOP(32'h0000_0000), .CLEAR_ON_RESET(1'b1)) u_dut0 (
    .clk(clk), .reset(rst_n), .pc(pc), .fetch_en(fetch_en), .stall(stall), .flush(flush),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .instruction(ins0), .inst_valid(v0), .fault(f0), .prog_err(pe0), .ready(rd0)
  );

  imem_fetch #(.DATA_W(32), .ADDR_W(32), .DEPTH(40), .NOP(32'h0000_0013), .CLEAR_ON_RESET(1'b0)) u_dut1 (
    .clk(clk), .reset(rst_n), .pc(pc), .fetch_en(fetch_en), .stall(stall), .flush(flush),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .instruction(ins1), .inst_valid(v1), .fault(f1), .prog_err(pe1), .ready(rd1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    bit          known;
    bit          valid;
    bit          fault;
    bit          perr;
    bit          ready;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int          m_depth [2] = '{64, 40};
  bit          m_clr   [2] = '{1'b1, 1'b0};
  logic [31:0] m_nop   [2] = '{32'h0000_0000, 32'h0000_0013};
  logic [31:0] m_mem   [2][64];
  bit          m_known [2][64];
  exp_t        m_out   [2];
  int          m_clear_left [2];

  int vectors = 0;
  int miscompares = 0;

  function automatic bit in_range(logic [31:0] a, int d);
    return (a % 32'd4 == 32'd0) && (a / 32'd4 < 32'(d));
  endfunction

  task automatic model_reset(int k);
    m_out[k].instr   = m_nop[k];
    m_out[k].known   = 1'b1;
    m_out[k].valid   = 1'b0;
    m_out[k].fault   = 1'b0;
    m_out[k].perr    = 1'b0;
    m_out[k].ready   = !m_clr[k];
    m_clear_left[k]  = m_clr[k] ? m_depth[k] : 0;
  endtask

  task automatic model_step(int k);
    if (!rst_n) begin
      model_reset(k);
      return;
    end
    if (m_clear_left[k] > 0) begin
      m_clear_left[k]--;
      if (m_clear_left[k] == 0) begin
        m_out[k].ready = 1'b1;
        for (int i = 0; i < m_depth[k]; i++) begin
          m_mem[k][i]   = m_nop[k];
          m_known[k][i] = 1'b1;
        end
      end
      return;
    end
    m_out[k].perr = prog_we && !in_range(prog_addr, m_depth[k]);
    if (flush) begin
      m_out[k].instr = m_nop[k];
      m_out[k].known = 1'b1;
      m_out[k].valid = 1'b0;
      m_out[k].fault = 1'b0;
    end else if (!stall) begin
      if (fetch_en && in_range(pc, m_depth[k])) begin
        m_out[k].instr = m_mem[k][pc / 4];
        m_out[k].known = m_known[k][pc / 4];
        m_out[k].valid = 1'b1;
        m_out[k].fault = 1'b0;
      end else if (fetch_en) begin
        m_out[k].instr = m_nop[k];
        m_out[k].known = 1'b1;
        m_out[k].valid = 1'b0;
        m_out[k].fault = 1'b1;
      end else begin
        m_out[k].valid = 1'b0;
        m_out[k].fault = 1'b0;
      end
    end
    if (prog_we && in_range(prog_addr, m_depth[k])) begin
      m_mem[k][prog_addr / 4]   = prog_data;
      m_known[k][prog_addr / 4] = 1'b1;
    end
  endtask

  // One clock edge; optionally drop reset right after it, before outputs are sampled.
  task automatic cycle(bit async_rst = 1'b0);
    @(posedge clk);
    model_step(0);
    model_step(1);
    if (async_rst) begin
      #1;
      rst_n = 1'b0;
      model_reset(0);
      model_reset(1);
    end
    q0.push_back(m_out[0]);
    q1.push_back(m_out[1]);
    #1;
  endtask

  task automatic set_in(bit fe, logic [31:0] p, bit st, bit fl, bit we, logic [31:0] pa, logic [31:0] pd);
    fetch_en  = fe;
    pc        = p;
    stall     = st;
    flush     = fl;
    prog_we   = we;
    prog_addr = pa;
    prog_data = pd;
  endtask

  function automatic logic [31:0] rand_addr();
    int s;
    s = int'($urandom_range(0, 19));
    if (s < 14) return 32'($urandom_range(0, 67)) * 32'd4;
    else if (s < 17) return 32'($urandom_range(0, 32'h10F));
    else return $urandom;
  endfunction

  task automatic check(int k, exp_t e);
    logic [31:0] ai;
    logic        av, af, ap, ar;
    bit          bad;
    if (k == 0) begin
      ai = ins0; av = v0; af = f0; ap = pe0; ar = rd0;
    end else begin
      ai = ins1; av = v1; af = f1; ap = pe1; ar = rd1;
    end
    bad = (e.known && (ai !== e.instr)) || (av !== e.valid) || (af !== e.fault) ||
          (ap !== e.perr) || (ar !== e.ready);
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL dut%0d vec%0d t=%0t: instr=%h/%h valid=%b/%b fault=%b/%b prog_err=%b/%b ready=%b/%b (got/exp)",
               k, vectors, $time, ai, e.instr, av, e.valid, af, e.fault, ap, e.perr, ar, e.ready);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (q0.size() > 0) check(0, q0.pop_front());
      if (q1.size() > 0) check(1, q1.pop_front());
    end
  end

  initial begin : driver
    int wait_cnt;
    cycle();
    cycle();
    rst_n = 1'b1;
    // Requests during the sweep: ignored by the swept instance, served by the other.
    set_in(1, 32'h10, 0, 0, 1, 32'h0, 32'hDEAD_BEEF);
    repeat (29) cycle();
    cycle(1'b1);
    set_in(0, 0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    rst_n = 1'b1;
    repeat (64) cycle();

    set_in(1, 32'h10, 0, 0, 0, 0, 0);                   cycle();
    set_in(0, 0, 0, 0, 1, 32'h0, 32'h2008_0020);         cycle();
    set_in(0, 0, 0, 0, 1, 32'h4, 32'h2009_0027);         cycle();
    set_in(1, 32'h0, 0, 0, 0, 0, 0);                    cycle();
    set_in(1, 32'h4, 0, 0, 0, 0, 0);                    cycle();
    set_in(1, 32'h4, 0, 0, 1, 32'h4, 32'h0);             cycle();
    set_in(1, 32'h4, 0, 0, 0, 0, 0);                    cycle();
    set_in(1, 32'h2, 0, 0, 0, 0, 0);                    cycle();
    set_in(1, 32'h100, 0, 0, 0, 0, 0);                  cycle();
    set_in(1, 32'h8000_0000, 0, 0, 0, 0, 0);            cycle();
    set_in(0, 0, 0, 0, 1, 32'h101, 32'h1234_5678);       cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);                        cycle();
    set_in(0, 0, 0, 0, 1, 32'h101, 32'h1111_1111);       cycle();
    set_in(0, 0, 0, 0, 1, 32'h8000_0000, 32'h2222_2222); cycle();
    set_in(1, 32'h0, 0, 0, 0, 0, 0);                    cycle();
    set_in(1, 32'h4, 1, 0, 0, 0, 0);                    repeat (3) cycle();
    set_in(1, 32'h4, 1, 1, 0, 0, 0);                    cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);                        cycle();
    set_in(0, 0, 0, 0, 1, 32'h9C, 32'hCAFE_F00D);        cycle();
    set_in(1, 32'h9C, 0, 0, 0, 0, 0);                   cycle();
    set_in(1, 32'hA0, 0, 0, 0, 0, 0);                   cycle();

    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        cycle(1'b1);
        set_in(0, 0, 0, 0, 0, 0, 0);
        cycle();
        rst_n = 1'b1;
      end
      set_in($urandom_range(0, 99) < 80, rand_addr(), $urandom_range(0, 9) == 0,
             $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0, rand_addr(), $urandom);
      cycle();
    end

    set_in(0, 0, 0, 0, 0, 0, 0);
    wait_cnt = 0;
    while ((q0.size() > 0 || q1.size() > 0) && wait_cnt < 10) begin
      @(negedge clk);
      #1;
      wait_cnt++;
    end
    if (q0.size() > 0 || q1.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d/%0d entries left, required 0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_fetch.md
# imem_fetch

Parametrised, clocked instruction memory for the pipelined CPU's IF stage. It replaces the combinational single-cycle instruction ROM with a registered fetch of one word per cycle. The block adds stall/flush control, alignment and range fault detection, a runtime program-load port, and an optional post-reset clear sweep. Its output feeds the IF/ID pipeline register directly.

## Interface
Parameters:
- DATA_W, 32, instruction word width
- ADDR_W, 32, PC / program-address width (byte addresses)
- DEPTH, 64, number of instruction words; any value >= 2
- NOP, 32'h0000_0000, word inserted on flush, fault and clear (width DATA_W)
- CLEAR_ON_RESET, 1, 1 = sweep all words to NOP after reset; 0 = contents untouched, ready immediately
- IDX_W, derived = clog2(DEPTH), word index width

Ports (clock and reset first):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- pc  in  ADDR_W  byte address to fetch
- fetch_en  in  1  request a fetch this cycle
- stall  in  1  hold current output (pipeline stall)
- flush  in  1  kill the fetched word (branch/jump taken)
- prog_we  in  1  program-load write strobe
- prog_addr  in  ADDR_W  byte address of word to write
- prog_data  in  DATA_W  word to write
- instruction  out  DATA_W  registered fetched word
- inst_valid  out  1  instruction is a real fetched word
- fault  out  1  last fetch was misaligned or out of range
- prog_err  out  1  one-cycle pulse: last prog_we was dropped
- ready  out  1  memory usable (clear sweep finished)

## Operation
- Word index = pc >> 2. An address is in range iff pc[1:0] == 0 and (pc >> 2) < DEPTH. The comparison uses the full ADDR_W-2 bit index, never a truncated index, so no address aliasing.
- FSM, two states:
  - CLEAR: clear_ptr counts 0..DEPTH-1 and writes NOP to mem[clear_ptr] each cycle. After the write at DEPTH-1 the FSM moves to RUN.
  - RUN: normal operation.
  - Reset enters CLEAR when CLEAR_ON_RESET = 1, otherwise RUN.
- ready = 1 exactly in RUN.
- While in CLEAR: fetch_en and prog_we are ignored. prog_err does not pulse. The outputs hold their reset values.
- Fetch, evaluated in RUN each cycle, with priority flush > stall > fetch:
  - flush: instruction <= NOP, inst_valid <= 0, fault <= 0. flush overrides stall.
  - stall (no flush): instruction, inst_valid and fault all hold.
  - fetch_en and in range: instruction <= mem[idx], inst_valid <= 1, fault <= 0.
  - fetch_en and out of range or misaligned: instruction <= NOP, inst_valid <= 0, fault <= 1.
  - no fetch_en: instruction holds, inst_valid <= 0, fault <= 0.
- Program load, in RUN:
  - prog_we with an in-range, aligned prog_addr writes mem[prog_addr >> 2] at the clock edge.
  - Otherwise the write is dropped and prog_err = 1 for the next cycle only.
  - A write in the same cycle as a fetch of the same word returns the OLD contents; the new word is visible from the following fetch.
- With CLEAR_ON_RESET = 0 the memory may be preloaded by simulation initial contents; the sweep never runs.

## Timing
- Reset values (asynchronous, while reset = 0): instruction = NOP, inst_valid = 0, fault = 0, prog_err = 0, clear_ptr = 0. ready = 0 if CLEAR_ON_RESET, else 1.
- Fetch latency is 1 cycle: pc sampled at edge N appears on instruction after edge N. Throughput is one word per cycle.
- Clear sweep occupies DEPTH cycles after reset release. ready rises after the DEPTH-th edge, so the first fetch is accepted on edge DEPTH+1.
- Reset asserted mid-sweep aborts the sweep. clear_ptr returns to 0 and the full sweep restarts after release.
- Reset asserted mid-fetch forces the outputs to their reset values immediately, without waiting for clk.
- prog_err is a single-cycle pulse per dropped write. Back-to-back bad writes give a continuous high.
- There is no combinational path from pc, fetch_en, stall or flush to any output.

## Test plan
- Reset and clear (DEPTH = 64, CLEAR_ON_RESET = 1): release reset -> ready = 0 for 64 cycles, 1 on cycle 65. A fetch of pc = 0x10 then returns 0x00000000 with inst_valid = 1.
- Load and fetch:
  - Write 0x20080020 at 0x0 and 0x20090027 at 0x4, then fetch 0x0, 0x4 back-to-back -> instruction 0x20080020 then 0x20090027 on consecutive cycles, valid high.
  - Write 0x00000000 to prog_addr 0x4 while fetching pc = 0x4 in the same cycle -> old word 0x20090027 is returned; the next fetch of 0x4 returns 0x00000000.
- Faults:
  - pc = 0x2 -> fault = 1, inst_valid = 0, instruction = NOP.
  - pc = 0x100 (DEPTH = 64) -> fault = 1.
  - prog_addr = 0x101 -> prog_err pulses 1 cycle, memory unchanged.
- Stall/flush: fetch 0x0, then assert stall for 3 cycles with pc = 0x4 -> instruction holds 0x20080020 and valid stays 1. Assert stall and flush together -> NOP, valid = 0 the next cycle.
- Reset mid-sweep: assert reset at sweep cycle 30 for 2 cycles -> outputs go to reset values immediately, and ready rises exactly 64 cycles after the second release.
- CLEAR_ON_RESET = 0 with DEPTH = 40: ready = 1 during and after reset. pc = 0x9C is accepted and pc = 0xA0 faults.
